// File: rtl/otter_cu_fsm.sv
// Multicycle sequencer for the OTTER RV32I core: INIT -> FETCH -> EXEC [-> WB] [-> INTR].
// Enables are decoded combinationally from state, wait counter, opcode and func3.
module otter_cu_fsm #(
  parameter int MEM_WAIT = 0,
  parameter bit INTR_EN  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       intr,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       rf_reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    INTR  = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t     state;
  logic [2:0] cnt;
  logic       mem_done;
  logic       take_intr;

  assign mem_done  = (cnt == WAIT_MAX);
  // intr only matters at the end-of-instruction decision points below
  assign take_intr = INTR_EN && intr;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= FETCH;
          cnt   <= '0;
        end
        FETCH: begin
          if (mem_done) state <= EXEC;
          else          cnt   <= cnt + 3'd1;
        end
        EXEC: begin
          cnt <= '0;
          if (opcode == OP_LOAD) state <= WB;
          else if (take_intr)    state <= INTR;
          else                   state <= FETCH;
        end
        WB: begin
          if (mem_done) begin
            cnt   <= '0;
            state <= take_intr ? INTR : FETCH;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        INTR: begin
          state <= FETCH;
          cnt   <= '0;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    rf_reset  = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state)
      INIT:  rf_reset = 1'b1;
      FETCH: memRDEN1 = 1'b1;
      EXEC: begin
        case (opcode)
          OP_LOAD: memRDEN2 = 1'b1;
          OP_STORE: begin
            memWE2  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYSTEM: begin
            pcWrite = 1'b1;
            if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end else if (func3 == 3'b001) begin
              csr_WE   = 1'b1;
              regWrite = 1'b1;
            end
          end
          // unknown opcodes retire as a NOP
          default: pcWrite = 1'b1;
        endcase
      end
      WB: begin
        if (mem_done) begin
          regWrite = 1'b1;
          pcWrite  = 1'b1;
        end else begin
          memRDEN2 = 1'b1;
        end
      end
      INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench: four parameterisations, one selected at a time, checked cycle by cycle against a phase-sequence model.
module tb_otter_cu_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_drv = 1'b0;
  logic [1:0] sel     = 2'd0;
  logic       intr    = 1'b0;
  logic [6:0] opcode  = 7'd0;
  logic [2:0] func3   = 3'd0;
  logic [11:0] ov [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic pcw, rgw, mwe, rd1, rd2, rfr, cwe, itk, mrt;
    logic [2:0] sd;
    otter_cu_fsm #(
      .MEM_WAIT(g == 1 ? 3 : (g == 2 ? 2 : 0)),
      .INTR_EN (g == 3 ? 1'b0 : 1'b1)
    ) dut (
      .CLK(clk), .RST_N(rst_drv && (sel == 2'(g))), .intr(intr),
      .opcode(opcode), .func3(func3),
      .pcWrite(pcw), .regWrite(rgw), .memWE2(mwe), .memRDEN1(rd1), .memRDEN2(rd2),
      .rf_reset(rfr), .csr_WE(cwe), .int_taken(itk), .mret_exec(mrt), .state_dbg(sd)
    );
    assign ov[g] = {sd, pcw, rgw, mwe, rd1, rd2, rfr, cwe, itk, mrt};
  end

  // expected-vector fields: [11:9] state, then one bit per enable
  localparam logic [11:0] PC = 12'h100, RW = 12'h080, WE = 12'h040, RD1 = 12'h020, RD2 = 12'h010;
  localparam logic [11:0] RFR = 12'h008, CSR = 12'h004, IT = 12'h002, MR = 12'h001;
  localparam logic [11:0] S_I0 = 12'h000, S_F = 12'h200, S_E = 12'h400, S_W = 12'h600, S_IN = 12'h800;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADDI = 7'b0010011, SYS = 7'b1110011;
  localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, BAD = 7'b1111111;

  logic [11:0] exp_cur = '0;
  logic        exp_vld = 1'b0;
  logic        seg_on = 1'b0, nseg_on = 1'b0;
  logic [2:0]  seg = '0, nseg = '0;
  logic [1:0]  nsel = '0;
  logic        done = 1'b0;
  string       tag = "reset", ntag = "reset";
  int          mw = 0;
  bit          ie = 1'b1;

  int n_tests = 0, n_fail = 0;
  int cyc_cnt [8], pc_cnt [8], rw_cnt [8], it_cnt [8];
  int both_cnt = 0;

  int lit_cyc [8] = '{4, 5, 7, 5, 4, 10, 8, 5};
  int lit_pc  [8] = '{2, 1, 1, 3, 2, 5, 0, 1};
  int lit_rw  [8] = '{2, 1, 1, 1, 1, 2, 0, 1};
  int lit_it  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};

  // exec-cycle enables straight from the opcode table
  function automatic logic [11:0] exec_out(logic [6:0] op, logic [2:0] f3);
    case (op)
      LW: return RD2;
      SW: return WE | PC;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011: return PC | RW;
      SYS: return (f3 == 3'd0) ? (MR | PC) : ((f3 == 3'd1) ? (CSR | RW | PC) : PC);
      default: return PC;
    endcase
  endfunction

  task automatic cyc(logic r, logic [6:0] op, logic [2:0] f3, logic ih, logic [11:0] e, logic chk);
    @(posedge clk); #1;
    rst_drv = r; opcode = op; func3 = f3; intr = ih;
    sel = nsel; seg = nseg; seg_on = nseg_on; tag = ntag;
    exp_cur = e; exp_vld = chk;
  endtask

  task automatic do_reset(logic [1:0] s, int m, bit e);
    nsel = s; mw = m; ie = e; nseg_on = 1'b0; ntag = "reset";
    cyc(1'b0, 7'd0, 3'd0, 1'b0, S_I0, 1'b0);
    cyc(1'b0, 7'd0, 3'd0, 1'b0, S_I0 | RFR, 1'b1);
    cyc(1'b1, 7'd0, 3'd0, 1'b0, S_I0 | RFR, 1'b1);
  endtask

  task automatic start_seg(logic [2:0] s, string nm);
    nseg = s; nseg_on = 1'b1; ntag = nm;
  endtask

  // one instruction: fetch (mw+1), exec, optional load writeback (mw+1), optional interrupt entry
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic ih);
    for (int i = 0; i <= mw; i++) cyc(1'b1, op, f3, ih, S_F | RD1, 1'b1);
    cyc(1'b1, op, f3, ih, S_E | exec_out(op, f3), 1'b1);
    if (op == LW) begin
      for (int i = 0; i < mw; i++) cyc(1'b1, op, f3, ih, S_W | RD2, 1'b1);
      cyc(1'b1, op, f3, ih, S_W | PC | RW, 1'b1);
    end
    if (ih && ie) cyc(1'b1, op, f3, ih, S_IN | IT | PC, 1'b1);
  endtask

  task automatic lit(string nm, int s, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s seg%0d: got %0d, expected %0d", nm, s, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      cyc_cnt[i] = 0; pc_cnt[i] = 0; rw_cnt[i] = 0; it_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (exp_vld) begin
        n_tests++;
        if (ov[sel] !== exp_cur) begin
          n_fail++;
          $display("FAIL %s cycle: got state=%0d en=%b, expected state=%0d en=%b",
                   tag, ov[sel][11:9], ov[sel][8:0], exp_cur[11:9], exp_cur[8:0]);
        end
      end
      if (seg_on) begin
        cyc_cnt[seg]++;
        pc_cnt[seg] += int'(ov[sel][8]);
        rw_cnt[seg] += int'(ov[sel][7]);
        it_cnt[seg] += int'(ov[sel][1]);
      end
      both_cnt += int'(ov[sel][7] & ov[sel][6]);
      if (done) begin
        for (int s = 0; s < 8; s++) begin
          lit("cycles", s, cyc_cnt[s], lit_cyc[s]);
          lit("pcWrite_count", s, pc_cnt[s], lit_pc[s]);
          lit("regWrite_count", s, rw_cnt[s], lit_rw[s]);
          lit("int_taken_count", s, it_cnt[s], lit_it[s]);
        end
        lit("memWE2_and_regWrite", 0, both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(2'd0, 0, 1'b1);
    start_seg(3'd0, "addi_mw0");
    run_instr(ADDI, 3'd0, 1'b0);
    run_instr(ADDI, 3'd0, 1'b0);

    do_reset(2'd1, 3, 1'b1);
    start_seg(3'd1, "addi_mw3");
    run_instr(ADDI, 3'd0, 1'b0);

    do_reset(2'd2, 2, 1'b1);
    start_seg(3'd2, "lw_mw2");
    run_instr(LW, 3'd2, 1'b0);

    do_reset(2'd0, 0, 1'b1);
    start_seg(3'd3, "sw_intr_en");
    run_instr(SW, 3'd2, 1'b1);
    run_instr(ADDI, 3'd0, 1'b0);

    do_reset(2'd3, 0, 1'b0);
    start_seg(3'd4, "sw_intr_dis");
    run_instr(SW, 3'd2, 1'b1);
    run_instr(ADDI, 3'd0, 1'b1);

    do_reset(2'd0, 0, 1'b1);
    start_seg(3'd5, "system_misc");
    run_instr(SYS, 3'd0, 1'b0);
    run_instr(SYS, 3'd1, 1'b0);
    run_instr(BAD, 3'd0, 1'b0);
    run_instr(BR, 3'd0, 1'b0);
    run_instr(LUI, 3'd0, 1'b0);

    do_reset(2'd1, 3, 1'b1);
    start_seg(3'd6, "lw_reset_mid_wb");
    for (int i = 0; i < 4; i++) cyc(1'b1, LW, 3'd2, 1'b0, S_F | RD1, 1'b1);
    cyc(1'b1, LW, 3'd2, 1'b0, S_E | RD2, 1'b1);
    cyc(1'b1, LW, 3'd2, 1'b0, S_W | RD2, 1'b1);
    cyc(1'b0, LW, 3'd2, 1'b0, S_W | RD2, 1'b1);
    cyc(1'b1, LW, 3'd2, 1'b0, S_I0 | RFR, 1'b1);
    start_seg(3'd7, "addi_after_reset");
    run_instr(ADDI, 3'd0, 1'b0);

    nseg_on = 1'b0; ntag = "tail";
    cyc(1'b0, 7'd0, 3'd0, 1'b0, S_I0, 1'b0);
    done = 1'b1;
  end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multicycle control FSM for the OTTER RV32I core.
- Sequences fetch, execute, load writeback and interrupt entry, and drives write and read enables to the PC, register file, memory and CSR file.
- Sits beside the combinational control-unit decoder, which still drives the datapath selects.
- Generalised with parameterised memory wait states and optional interrupt support.

Parameters:
- MEM_WAIT, 0, extra stall cycles per memory read (legal range 0..7); each read phase lasts MEM_WAIT+1 cycles.
- INTR_EN, 1, 1 = interrupt handling enabled; 0 = intr input ignored and INTR state unreachable.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- intr  in  1  level interrupt request, already synchronised.
- opcode  in  7  ir[6:0].
- func3  in  3  ir[14:12].
- pcWrite  out  1  PC load enable.
- regWrite  out  1  register file write enable.
- memWE2  out  1  data memory write enable.
- memRDEN1  out  1  instruction memory read enable.
- memRDEN2  out  1  data memory read enable.
- rf_reset  out  1  reset to PC and register file.
- csr_WE  out  1  CSR write enable.
- int_taken  out  1  interrupt entry strobe to CSR/PC logic.
- mret_exec  out  1  MRET strobe.
- state_dbg  out  3  current state encoding.

Behaviour:
- States and encoding: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4. Codes 5..7 are illegal and go to INIT next cycle with all outputs 0.
- Reset: RST_N=0 sampled at a CLK edge puts the FSM in INIT and clears the wait counter, from any state including mid-WB or mid-store. The abandoned operation is not completed.
- Output timing: all outputs are combinational from state, wait counter, opcode, func3 and intr. Any output not listed for a state is 0.
- Wait counter: 3 bits, cleared on entry to FETCH and WB, increments each cycle in those states, saturates at MEM_WAIT.
- INIT:
  - rf_reset=1.
  - Next state FETCH, unconditionally.
- FETCH:
  - memRDEN1=1 for every cycle.
  - Next state EXEC when counter==MEM_WAIT; otherwise stay in FETCH.
- EXEC (one cycle), decode by opcode:
  - LOAD 0000011: memRDEN2=1 only. Next state WB.
  - STORE 0100011: memWE2=1, pcWrite=1.
  - BRANCH 1100011: pcWrite=1.
  - LUI, AUIPC, JAL, JALR, OP_IMM 0010011, OP 0110011: pcWrite=1, regWrite=1.
  - SYSTEM 1110011, func3=000 (MRET): mret_exec=1, pcWrite=1.
  - SYSTEM 1110011, func3=001 (CSRRW): csr_WE=1, regWrite=1, pcWrite=1.
  - SYSTEM 1110011, other func3: pcWrite=1.
  - Any other opcode: pcWrite=1 only; executes as a NOP, no trap.
  - Next state for non-LOAD: INTR if INTR_EN and intr are both 1, else FETCH.
- WB:
  - memRDEN2=1 on every cycle while counter<MEM_WAIT.
  - On the cycle where counter==MEM_WAIT: regWrite=1, pcWrite=1.
  - Exit after that cycle: INTR if INTR_EN and intr are both 1, else FETCH.
- INTR:
  - int_taken=1, pcWrite=1 for exactly one cycle.
  - Next state FETCH.
  - intr still high does not cause back-to-back INTR; it is only sampled at instruction end.
- intr sampling: sampled only at the EXEC (non-load) and final WB decision points. Pulses outside those points are lost; the source must hold the request level.
- Instruction latency: (MEM_WAIT+1) + 1 cycles for non-loads; (MEM_WAIT+1)*2 + 1 for loads; +1 if an interrupt is taken.
- memWE2 and regWrite are never both 1 in the same cycle.
- pcWrite is 1 exactly once per retired instruction, plus once per interrupt entry.

Test Plan:
- Reset entry: MEM_WAIT=0, RST_N low for 2 edges then high. Required: state_dbg=0 with rf_reset=1; next cycle state_dbg=1 with memRDEN1=1; then EXEC.
- ADDI (opcode 0010011), MEM_WAIT=0. Required: FETCH 1 cycle; EXEC asserts pcWrite=1, regWrite=1, memWE2=0; next state FETCH. Repeat with MEM_WAIT=3. Required: memRDEN1 high 4 cycles before EXEC.
- LW (0000011), MEM_WAIT=2. Required: FETCH 3 cycles; EXEC memRDEN2=1, pcWrite=0; WB memRDEN2 for 2 cycles, then regWrite=pcWrite=1 on the 3rd WB cycle; 7 cycles total.
- SW (0100011) with intr=1 held, INTR_EN=1. Required: EXEC memWE2=1, pcWrite=1; next cycle INTR with int_taken=1; then FETCH. Same stimulus with INTR_EN=0. Required: int_taken never asserts.
- MRET (1110011, func3=000). Required: mret_exec=1, pcWrite=1, regWrite=0. CSRRW (func3=001). Required: csr_WE=1, regWrite=1. Illegal opcode 1111111. Required: pcWrite=1 only.
- Reset mid-WB: LW, MEM_WAIT=3, drive RST_N=0 on the 2nd WB cycle. Required: next cycle INIT, regWrite never asserted for that load, fetch restarts after release.
